// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 receiver: event layout, scan-code
// prefixes and the deframer state encoding.
package ps2_pkg;

  localparam int EVT_W   = 10;
  localparam int EXT_BIT = 9;
  localparam int BRK_BIT = 8;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/ps2_rx_fifo_sync_filter.sv
// Brings ps2_clk/ps2_data into the clk domain, rejects short ps2_clk glitches
// and emits a one-cycle strobe on each filtered falling edge.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic strobe
);

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_f;
  logic [3:0] flt_cnt;
  logic       flip;

  // flip fires on the FILTER_LEN-th consecutive sample that disagrees with clk_f
  assign flip   = (clk_sync[1] != clk_f) && (flt_cnt == 4'(FILTER_LEN - 1));
  assign data_s = data_sync[1];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_f     <= 1'b1;
      flt_cnt   <= '0;
      strobe    <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      strobe    <= flip && clk_f;
      if (clk_sync[1] == clk_f) begin
        flt_cnt <= '0;
      end else if (flip) begin
        clk_f   <= ~clk_f;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: deframes and checks 11-bit frames, folds
// E0/F0 prefixes into 10-bit key events and queues them in a show-ahead FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH_LOG2  = 3,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 20000,
  parameter int DECODE      = 1
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [EVT_W-1:0]      data,
  output logic                  ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  parity_err,
  output logic                  frame_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int WD_W  = $clog2(TIMEOUT_CYC);

  logic                  strobe;
  logic                  data_s;
  rx_state_e             state, state_nxt;
  logic [2:0]            bit_cnt;
  logic [7:0]            shreg;
  logic                  par_bit;
  logic [WD_W-1:0]       wd_cnt;
  logic                  timeout;
  logic                  frame_ok;
  logic                  byte_done;
  logic                  frame_bad;
  logic                  ext_f, brk_f;
  logic                  is_prefix;
  logic                  push;
  logic [EVT_W-1:0]      push_data;
  logic [EVT_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic                  pop, full, wr_en, ovf_set;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data_s   (data_s),
    .strobe   (strobe)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = IDLE;
    end else if (strobe) begin
      case (state)
        IDLE:    if (!data_s) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else if (strobe) begin
      case (state)
        IDLE:    bit_cnt <= '0;
        DATA: begin
          shreg   <= {data_s, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        PARITY:  par_bit <= data_s;
        default: ;
      endcase
    end
  end

  // A strobe on the same cycle counts as bus activity, so it never times out.
  assign timeout = (state != IDLE) && !strobe && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                        wd_cnt <= '0;
    else if (state == IDLE || strobe) wd_cnt <= '0;
    else                              wd_cnt <= wd_cnt + WD_W'(1);
  end

  assign frame_ok  = data_s && (^{shreg, par_bit});
  assign byte_done = strobe && (state == STOP) && frame_ok;
  assign frame_bad = strobe && (state == STOP) && !frame_ok;

  assign is_prefix = (DECODE != 0) && ((shreg == PFX_EXT) || (shreg == PFX_BRK));
  assign push      = byte_done && !is_prefix;
  assign push_data = (DECODE != 0) ? {ext_f, brk_f, shreg} : {2'b00, shreg};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ext_f <= 1'b0;
      brk_f <= 1'b0;
    end else if (timeout) begin
      ext_f <= 1'b0;
      brk_f <= 1'b0;
    end else if (byte_done && DECODE != 0) begin
      if (shreg == PFX_EXT) begin
        ext_f <= 1'b1;
      end else if (shreg == PFX_BRK) begin
        brk_f <= 1'b1;
      end else begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end
    end
  end

  // count never exceeds DEPTH, so its MSB alone marks a full FIFO
  assign full    = count[DEPTH_LOG2];
  assign pop     = rd_en && (count != '0);
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign ready   = (count != '0);
  assign data    = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (frame_bad)    parity_err <= 1'b1;
      else if (clr_err) parity_err <= 1'b0;
      if (timeout)      frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: table-driven directed frames, corner
// sequences, then random frames checked against a queue-based model.
module tb_ps2_rx_fifo;

  localparam int DEPTH_LOG2  = 2;
  localparam int DEPTH       = 4;
  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 100;
  localparam int H           = 20;

  logic                clk = 1'b0;
  logic                clrn = 1'b0;
  logic                ps2_clk = 1'b1;
  logic                ps2_data = 1'b1;
  logic                rd_en = 1'b0;
  logic                clr_err = 1'b0;
  logic [9:0]          data;
  logic                ready;
  logic [DEPTH_LOG2:0] count;
  logic                overflow, parity_err, frame_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] code;
    bit         flip_par;
    bit         bad_stop;
    int         mode;
    int         exp_count;
    bit         exp_perr;
  } vec_t;

  vec_t       vecs[10];
  logic [9:0] mq[$];
  bit         m_ext, m_brk, m_ovf, m_perr;

  ps2_rx_fifo #(
    .DEPTH_LOG2  (DEPTH_LOG2),
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .DECODE      (1)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .data       (data),
    .ready      (ready),
    .count      (count),
    .overflow   (overflow),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] code, input bit flip_par, input bit bad_stop);
    logic par;
    par = (~^code) ^ flip_par;
    return {~bad_stop, par, code, 1'b0};
  endfunction

  // mode: 0 plain, 1 check ready latency, 2 pop on push cycle, 3 glitches
  task automatic hold_half(input logic level, input bit glitch);
    if (glitch) begin
      repeat (8) @(negedge clk);
      ps2_clk = ~level;
      repeat (3) @(negedge clk);
      ps2_clk = level;
      repeat (H - 11) @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
  endtask

  task automatic send_bits(input logic [10:0] f, input int nbits, input int mode);
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      hold_half(1'b1, mode == 3);
      ps2_clk = 1'b0;
      if (i == 10 && mode == 1) begin
        repeat (6) @(posedge clk);
        #1;
        checkOutput("ready_latency_lo", 32'(ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("ready_latency_hi", 32'(ready), 32'd1);
      end else if (i == 10 && mode == 2) begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("head_at_push", 32'(data), 32'h001);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
      hold_half(1'b0, mode == 3);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    hold_half(1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] code, input bit flip_par, input bit bad_stop, input int mode);
    send_bits(make_frame(code, flip_par, bad_stop), 11, mode);
  endtask

  task automatic applyStimulus(input vec_t v);
    send_frame(v.code, v.flip_par, v.bad_stop, v.mode);
    checkOutput("vec_count", 32'(count), v.exp_count);
    checkOutput("vec_ready", 32'(ready), 32'(v.exp_count != 0));
    checkOutput("vec_parity_err", 32'(parity_err), 32'(v.exp_perr));
  endtask

  task automatic pop_expect(input logic [9:0] exp);
    @(negedge clk);
    checkOutput("pop_ready", 32'(ready), 32'd1);
    checkOutput("pop_data", 32'(data), 32'(exp));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr;
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  // reference: a good byte either sets a prefix flag or becomes one event
  task automatic model_frame(input logic [7:0] code, input bit bad);
    if (bad) begin
      m_perr = 1'b1;
    end else if (code == 8'hE0) begin
      m_ext = 1'b1;
    end else if (code == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (mq.size() < DEPTH) mq.push_back({m_ext, m_brk, code});
      else                   m_ovf = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] code;
    logic [9:0] exp;
    bit         fp, bs;
    int         r, k;

    vecs[0] = '{8'h1C, 1'b0, 1'b0, 1, 1, 1'b0};
    vecs[1] = '{8'hF0, 1'b0, 1'b0, 0, 1, 1'b0};
    vecs[2] = '{8'h1C, 1'b0, 1'b0, 0, 2, 1'b0};
    vecs[3] = '{8'hE0, 1'b0, 1'b0, 0, 2, 1'b0};
    vecs[4] = '{8'h75, 1'b0, 1'b0, 0, 3, 1'b0};
    vecs[5] = '{8'hE0, 1'b0, 1'b0, 0, 3, 1'b0};
    vecs[6] = '{8'hF0, 1'b0, 1'b0, 0, 3, 1'b0};
    vecs[7] = '{8'h75, 1'b0, 1'b0, 0, 4, 1'b0};
    vecs[8] = '{8'h1C, 1'b1, 1'b0, 0, 0, 1'b1};
    vecs[9] = '{8'h1C, 1'b0, 1'b1, 0, 0, 1'b1};

    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 32'(ready), 32'd0);
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_flags", 32'({overflow, parity_err, frame_err}), 32'd0);
    clrn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
    pop_expect(10'h01C);
    pop_expect(10'h11C);
    pop_expect(10'h275);
    pop_expect(10'h375);
    for (int i = 8; i < 10; i++) applyStimulus(vecs[i]);
    pulse_clr();
    @(negedge clk);
    checkOutput("perr_cleared", 32'(parity_err), 32'd0);

    // a pending E0 must be forgotten when a later frame times out
    send_frame(8'hE0, 1'b0, 1'b0, 0);
    send_bits(make_frame(8'hFF, 1'b0, 1'b0), 4, 0);
    checkOutput("frame_err_early", 32'(frame_err), 32'd0);
    repeat (TIMEOUT_CYC) @(negedge clk);
    checkOutput("frame_err_set", 32'(frame_err), 32'd1);
    checkOutput("timeout_count", 32'(count), 32'd0);
    checkOutput("timeout_perr", 32'(parity_err), 32'd0);
    send_frame(8'h32, 1'b0, 1'b0, 0);
    pop_expect(10'h032);
    pulse_clr();
    @(negedge clk);
    checkOutput("frame_err_cleared", 32'(frame_err), 32'd0);

    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, 0);
    checkOutput("ovf_count", 32'(count), 32'd4);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) pop_expect(10'(i));
    @(negedge clk);
    checkOutput("drained_ready", 32'(ready), 32'd0);
    pulse_clr();
    @(negedge clk);
    checkOutput("ovf_cleared", 32'(overflow), 32'd0);

    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b0, 0);
    send_frame(8'h05, 1'b0, 1'b0, 2);
    checkOutput("fullpp_count", 32'(count), 32'd4);
    checkOutput("fullpp_ovf", 32'(overflow), 32'd0);
    for (int i = 2; i <= 5; i++) pop_expect(10'(i));

    send_frame(8'hA5, 1'b0, 1'b0, 3);
    checkOutput("glitch_count", 32'(count), 32'd1);
    checkOutput("glitch_head", 32'(data), 32'h0A5);
    checkOutput("glitch_errs", 32'({parity_err, frame_err}), 32'd0);

    send_frame(8'h11, 1'b1, 1'b0, 0);
    send_bits(make_frame(8'h3C, 1'b0, 1'b0), 5, 0);
    @(negedge clk);
    clrn = 1'b0;
    #1;
    checkOutput("async_rst_ready", 32'(ready), 32'd0);
    checkOutput("async_rst_count", 32'(count), 32'd0);
    checkOutput("async_rst_flags", 32'({overflow, parity_err, frame_err}), 32'd0);
    repeat (5) @(negedge clk);
    clrn = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    checkOutput("post_rst_count", 32'(count), 32'd1);
    pop_expect(10'h03C);

    mq.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_ovf = 1'b0;
    m_perr = 1'b0;
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      code = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
      fp = ($urandom_range(0, 7) == 0);
      bs = ($urandom_range(0, 9) == 0);
      send_frame(code, fp, bs, 0);
      model_frame(code, fp || bs);
      checkOutput("rnd_count", 32'(count), 32'(mq.size()));
      checkOutput("rnd_overflow", 32'(overflow), 32'(m_ovf));
      checkOutput("rnd_parity_err", 32'(parity_err), 32'(m_perr));
      k = $urandom_range(0, mq.size());
      for (int j = 0; j < k; j++) begin
        exp = mq.pop_front();
        pop_expect(exp);
      end
      if ($urandom_range(0, 4) == 0) begin
        pulse_clr();
        m_ovf = 1'b0;
        m_perr = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("rnd_final_count", 32'(count), 32'(mq.size()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Parametrised PS/2 device-to-host receiver: synchronises and de-glitches ps2_clk, deframes 11-bit frames, checks start, odd parity and stop bits.
- Optional scan-code prefix decoding (E0 extended, F0 break) folds prefixes into 10-bit key events.
- Events go into a show-ahead FIFO read by the CPU/peripheral bus side.
- Adds configurable FIFO depth, glitch filtering, a frame-timeout watchdog, sticky error flags and a fill count.

Parameters:
- DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 entries (legal 1..6).
- FILTER_LEN, 4, consecutive equal synchronised ps2_clk samples required before the filtered clock changes (legal 1..15).
- TIMEOUT_CYC, 20000, clk cycles without a filtered falling edge mid-frame before the frame is aborted (legal >= 16).
- DECODE, 1, 1 = fold E0/F0 prefixes into events; 0 = push raw bytes.

Ports:
- clk  in  1  system clock; all state on posedge.
- clrn  in  1  reset, asynchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous to clk.
- ps2_data  in  1  raw PS/2 data pin, asynchronous to clk.
- rd_en  in  1  pop FIFO head this cycle; ignored when ready=0.
- clr_err  in  1  one-cycle pulse clears overflow, parity_err and frame_err.
- data  out  10  FIFO head: [9]=ext, [8]=brk, [7:0]=code; valid while ready=1.
- ready  out  1  FIFO non-empty.
- count  out  DEPTH_LOG2+1  FIFO occupancy, 0..2**DEPTH_LOG2.
- overflow  out  1  sticky: a completed event was dropped because the FIFO was full.
- parity_err  out  1  sticky: a frame failed its start, parity or stop check.
- frame_err  out  1  sticky: a frame timed out.

Behaviour:
- Reset (clrn=0, asynchronous): FIFO pointers=0, count=0, ready=0, overflow/parity_err/frame_err=0, FSM=IDLE, prefix flags=0, synchronisers and filter preset to 1 (idle bus).
- Input path: ps2_clk and ps2_data each pass through 2-flop synchronisers. The filter counter reloads whenever the synchronised clock equals filtered clk_f. clk_f toggles after FILTER_LEN consecutive differing samples. The sample strobe is a one-cycle pulse when clk_f goes 1->0; on that cycle synchronised ps2_data is captured.
- FSM (strobe-driven):
  - IDLE: on strobe, if data=0 go to DATA, bitcnt=0. If data=1 the stray edge is ignored.
  - DATA: shift bits LSB first; after 8 strobes go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: on strobe, check stop=1 and odd parity over 8 data bits + parity. Pass: issue a byte-done pulse. Fail: set parity_err and push nothing. Return to IDLE in both cases.
- Watchdog: counter clears on every strobe and in IDLE. If not in IDLE and the counter reaches TIMEOUT_CYC-1: go to IDLE, set frame_err, clear prefix flags, push nothing.
- Decode (DECODE=1), evaluated on byte-done:
  - Byte E0: set ext, no push.
  - Byte F0: set brk, no push.
  - Any other byte: push {ext,brk,byte}, then clear both flags.
  - DECODE=0: push {2'b00,byte} for every byte.
- Latency: stop-bit strobe at cycle T -> entry written at the T+1 edge -> ready=1 and count updated from T+1.
- FIFO:
  - Show-ahead: data = mem[rptr] combinationally; contents undefined when ready=0.
  - rd_en while ready=1 advances rptr by 1; pointers wrap modulo depth.
  - Push when count<depth: write and advance wptr.
  - Push when full with no pop in the same cycle: entry dropped, overflow set, FIFO unchanged.
  - Push and pop in the same cycle (including when full): both occur, count unchanged, no overflow.
  - rd_en while empty: no effect; count never underflows.
- Error clear: clr_err clears the three sticky flags. If clr_err and a new error coincide, the flag ends set.
- No FIFO flush other than reset. A partial frame at reset is discarded.

Decomposition:
- Package ps2_pkg: event width constant (10), field positions EXT_BIT=9 and BRK_BIT=8, prefix constants 8'hE0 and 8'hF0, FSM state enum {IDLE, DATA, PARITY, STOP}.
- One natural sub-module: ps2_sync_filter (synchroniser + glitch filter + falling-edge strobe, parameter FILTER_LEN).
- FIFO stays inline.

Test Plan:
- DECODE=1: send frames 1C, F0 1C, E0 75, E0 F0 75 -> FIFO holds 01C, 11C, 275, 375 in order; ready rises 1 cycle after each final stop-bit strobe; count=4.
- Send 1C with bad parity, then 1C with stop=0 -> parity_err=1, count=0. clr_err pulse -> parity_err=0.
- After start+3 data bits, hold ps2_clk high for TIMEOUT_CYC cycles -> frame_err=1, FSM=IDLE. Next frame 32 received as 032.
- DEPTH_LOG2=2, no reads, send 5 bytes 01..05 -> count=4, overflow=1. Pops return 001,002,003,004.
- Full FIFO with rd_en asserted on the push cycle -> count stays 4, overflow stays 0, last entry present.
- 1-cycle ps2_clk glitches (FILTER_LEN=4) mid-frame -> no extra strobes; byte A5 received intact. clrn asserted mid-frame -> all outputs 0 immediately (asynchronous).
